axis_coeff_framer: RTL
======================

Name: axis_coeff_framer

Overview:
- Downstream stage of the coefficient multiplier in the fv_enc datapath.
- Accepts the QW-bit product stream and buffers it in a DEPTH-entry FIFO so the multiplier can tolerate consumer backpressure.
- Re-frames the stream into N-coefficient polynomials with a regenerated tlast, checks incoming frame length, and counts completed frames for the dump/checker stage that follows.

Parameters:
N, 16, coefficients per polynomial frame (>=2)
QW, 64, coefficient data width
DEPTH, 16, FIFO entries (power of 2, >=2)

Ports:
clk  in  1  single clock; all state updates on the rising edge
s_rst_n  in  1  synchronous active-low reset
s_tdata  in  QW  input coefficient
s_tvalid  in  1  input beat valid
s_tready  out  1  input beat accepted when s_tvalid && s_tready
s_tlast  in  1  upstream end-of-frame marker
m_tdata  out  QW  output coefficient
m_tvalid  out  1  output beat valid
m_tready  in  1  downstream ready
m_tlast  out  1  regenerated end-of-frame
frame_cnt  out  16  completed output frames, wraps at 2^16
err_len  out  1  sticky frame-length error
fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset, sampled on the clk edge while s_rst_n=0: all outputs 0.
  - Covers s_tready, m_tvalid, m_tdata, m_tlast, frame_cnt, err_len and fifo_level.
  - FIFO pointers and counters clear. In-flight data is discarded.
- s_tready=1 from the first edge after s_rst_n returns high, provided the FIFO is not full.
- FIFO storage is QW+1 bits wide: data plus an eof bit.
- Write condition: s_tvalid && s_tready. s_tready = (fifo_level < DEPTH), a combinational function of level only.
- Full-FIFO rule: when full, s_tready=0 even if a read occurs in the same cycle. No write pass-through.
- Input beat index in_idx counts 0..N-1 on each accepted beat.
  - eof = (in_idx==N-1) || s_tlast.
  - On eof, in_idx returns to 0. Otherwise in_idx increments.
- Length check:
  - err_len sets if s_tlast=1 with in_idx!=N-1 (early tlast).
  - err_len sets if s_tlast=0 with in_idx==N-1 (missing tlast).
  - err_len clears only on reset.
  - An early tlast resynchronises framing: the next beat starts a new frame.
- Output side is first-word fall-through:
  - m_tvalid = (fifo_level != 0).
  - m_tdata and m_tlast show the head entry; m_tlast is the stored eof bit.
  - Read condition: m_tvalid && m_tready.
- Latency: a beat accepted at edge k is visible on m_tdata with m_tvalid=1 after edge k. Minimum one cycle, no combinational input-to-output path.
- When empty, m_tvalid=0. m_tdata and m_tlast hold their last values (0 after reset).
- Simultaneous read and write with FIFO not full: level is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Level distinguishes full from empty.
- frame_cnt increments on each m_tvalid && m_tready && m_tlast.
- Stability: m_tdata and m_tlast stay stable while m_tvalid && !m_tready.

Optional Feature:
- Macro: FRAMER_CHECKSUM_EN.
- Enabled:
  - An output FSM with states DATA and CSUM is added. A QW-bit XOR accumulator over all data beats transferred in the current frame is kept.
  - DATA: FIFO beats pass through with m_tlast forced to 0.
  - DATA -> CSUM when an eof beat transfers.
  - CSUM:
    - The FIFO is not read.
    - Outputs are m_tvalid=1, m_tdata=accumulator, m_tlast=1.
    - On m_tready: the accumulator clears, frame_cnt increments, and the FSM returns to DATA.
  - Reset puts the FSM in DATA with the accumulator at 0.
- Disabled: no checksum beat, no FSM; behaviour exactly as above.

Test Plan:
1. Hold s_rst_n=0 for 3 cycles with s_tvalid=1 -> s_tready=0, m_tvalid=0, fifo_level=0, frame_cnt=0; s_tready=1 on the first edge after release.
2. 16 beats of data 1..16, s_tlast on beat 16, m_tready=1 -> data 1..16 out one cycle after accept, m_tlast only on 16, frame_cnt=1, err_len=0.
3. m_tready=0, offer 20 beats -> 16 accepted, s_tready=0 after the 16th, fifo_level=16; then m_tready=1 -> 1..16 drained in order, beats 17..20 then accepted, no loss or duplication.
4. s_tlast on beat 10, followed by a correct 16-beat frame -> err_len=1 and stays 1, m_tlast on output beats 10 and 26, frame_cnt=2.
5. 16 beats with s_tlast=0 throughout -> err_len=1, m_tlast still on output beat 16, frame_cnt=1.
6. FRAMER_CHECKSUM_EN defined, frame 1..16 -> 17 output beats, beat 16 with m_tlast=0, beat 17 m_tdata=0x10 with m_tlast=1, frame_cnt=1.

Source files
------------

// File: rtl/axis_coeff_framer.sv
// axis_coeff_framer: FIFO-buffered re-framer of a coefficient stream into N-beat frames, with frame-length error flag and frame counter; ports clk, s_rst_n, s_axis (tdata/tvalid/tready/tlast), m_axis (tdata/tvalid/tready/tlast), frame_cnt, err_len, fifo_level; define FRAMER_CHECKSUM_EN to append an XOR checksum beat to each frame
module axis_coeff_framer #(
  parameter int N = 16,
  parameter int QW = 64,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    s_rst_n,
  input  logic [QW-1:0]           s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [QW-1:0]           m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [15:0]             frame_cnt,
  output logic                    err_len,
  output logic [$clog2(DEPTH):0]  fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(N);
  logic [QW:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] in_idx;
  logic [QW-1:0] hold_data;
  logic [QW:0] head;
  logic run, wr, rd, eof, empty, fdone;
  assign head = mem[rd_ptr];
  assign empty = fifo_level == '0;
  assign s_tready = run && fifo_level < (AW+1)'(DEPTH);
  assign wr = s_tvalid && s_tready;
  assign eof = (in_idx == IW'(N-1)) || s_tlast;
`ifdef FRAMER_CHECKSUM_EN
  typedef enum logic {DATA, CSUM} state_t;
  state_t state;
  logic [QW-1:0] acc;
  assign rd = !empty && m_tready && state == DATA;
  assign fdone = state == CSUM && m_tready;
  assign m_tvalid = state == CSUM || !empty;
  assign m_tdata = state == CSUM ? acc : empty ? hold_data : head[QW-1:0];
  assign m_tlast = state == CSUM;
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state <= DATA;
      acc <= '0;
    end else if (state == DATA) begin
      if (rd) begin
        acc <= acc ^ head[QW-1:0];
        if (head[QW]) state <= CSUM;
      end
    end else if (m_tready) begin
      acc <= '0;
      state <= DATA;
    end
  end
`else
  logic hold_last;
  assign rd = !empty && m_tready;
  assign fdone = rd && head[QW];
  assign m_tvalid = !empty;
  assign m_tdata = empty ? hold_data : head[QW-1:0];
  assign m_tlast = empty ? hold_last : head[QW];
  always_ff @(posedge clk) begin
    if (!s_rst_n) hold_last <= 1'b0;
    else if (rd) hold_last <= head[QW];
  end
`endif
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {eof, s_tdata};
  end
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      run <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      in_idx <= '0;
      err_len <= 1'b0;
      frame_cnt <= '0;
      hold_data <= '0;
    end else begin
      run <= 1'b1;
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
        in_idx <= eof ? '0 : in_idx + 1'b1;
        if (s_tlast != (in_idx == IW'(N-1))) err_len <= 1'b1;
      end
      if (rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold_data <= head[QW-1:0];
      end
      fifo_level <= fifo_level + (AW+1)'(wr) - (AW+1)'(rd);
      if (fdone) frame_cnt <= frame_cnt + 1'b1;
    end
  end
endmodule
